tl_tx_vc_arbiter: RTL and testbench
===================================

Name: tl_tx_vc_arbiter

Overview:
Transmit-side counterpart of the RX virtual-channel buffers.
- Selects one TLP at a time from the heads of the posted, non-posted and completion TX buffers, applying PCIe ordering rules and flow-control credit gating.
- Serialises the selected TLP onto the link-side beat stream as one header beat followed by data beats.
- Pops the TX buffers and reports the credits it consumed to the FC tracker.

Parameters:
DW, 32, bits per double word
HDR_CREDIT_WIDTH, 8, width of available header-credit inputs
DATA_CREDIT_WIDTH, 12, width of available data-credit inputs and the consumed-credit output

Ports:
i_clk  in  1  clock; single clock domain
i_rst  in  1  reset, asynchronous, active-high
i_{p,np,cpl}_valid  in  1 each  TLP present at buffer head
i_{p,np,cpl}_has_data  in  1 each  TLP carries payload
i_{p,np,cpl}_length  in  10 each  payload length in DW; 0 means 1024
i_{p,np,cpl}_hdr  in  4*DW each  head TLP header
i_{p,np,cpl}_data  in  8*DW each  current head data beat
o_{p,np,cpl}_rd_hdr  out  1 each  pop header (1-cycle pulse)
o_{p,np,cpl}_rd_data  out  1 each  pop one data beat (1-cycle pulse)
i_{p,np,cpl}_hdr_credits  in  HDR_CREDIT_WIDTH each  available header credits
i_{p,np,cpl}_data_credits  in  DATA_CREDIT_WIDTH each  available data credits (1 credit = 4 DW)
o_fc_consume  out  3  one-hot {p,np,cpl} consume strobe
o_fc_data_consumed  out  DATA_CREDIT_WIDTH  data credits consumed with the strobe
o_tx_valid  out  1  beat valid
i_tx_ready  in  1  link side accepts beat
o_tx_sop  out  1  header beat
o_tx_eop  out  1  last beat of TLP
o_tx_type  out  2  00 P, 01 NP, 10 CPL
o_tx_beat  out  8*DW  header beat = {4*DW zeros, hdr}; data beat = data

Behaviour:
Reset:
- All outputs are 0, the FSM is in IDLE, and the round-robin pointer selects NP.

Arithmetic:
- L = length, with 0 mapped to 1024.
- Credits needed = ceil(L/4), range 1..256; 0 when has_data=0.
- Beats = ceil(L/8), range 1..128; uses an 8-bit down-counter.

Eligibility:
- A class is eligible when valid=1, hdr_credits>=1 and data_credits>=needed.
- Comparisons are unsigned.

Ordering:
- If P is valid, only P may be granted. NP and CPL are blocked even when P is credit-starved, so reads and completions never pass posted writes.
- If P is not valid, choose between NP and CPL by round-robin. The pointer toggles to the other class after each NP/CPL grant. If only one of them is eligible, that one wins.

FSM IDLE -> HDR -> DATA -> IDLE:
- IDLE:
  - Arbitrate combinationally from current inputs.
  - On a grant, register the class, header and beat count, pulse o_fc_consume[class] with o_fc_data_consumed for one cycle, and go to HDR.
  - With no grant, stay in IDLE.
- HDR:
  - Drive o_tx_valid=1, o_tx_sop=1, o_tx_eop = !has_data.
  - Hold all outputs stable until i_tx_ready.
  - On acceptance, pulse rd_hdr for the class.
  - Go to DATA if has_data, else to IDLE.
- DATA:
  - Drive o_tx_beat from the registered class's data input.
  - o_tx_eop=1 when the remaining count = 1.
  - Each accepted beat pulses rd_data and decrements the count.
  - After the last accepted beat, go to IDLE.

Timing and boundaries:
- Minimum gap between TLPs is one IDLE cycle.
- Latency from valid to the first o_tx_valid is 1 cycle.
- Inputs that change during HDR/DATA do not affect the TLP in flight; the class and count are latched.
- Credits are consumed exactly once per TLP, at grant.
- Credit inputs equal to the needed value grant. Credit inputs one below block.
- If the link stalls (i_tx_ready=0) indefinitely, the block holds state with no pops.
- Reset asserted mid-TLP returns the FSM to IDLE immediately and clears all outputs asynchronously. No partial pop or consume completes.

Test Plan:
1. P len=16, credits hdr=1/data=4, ready=1 -> grant next cycle; consume P with 4; header beat sop; data beats 2, eop on the 2nd; rd_hdr once, rd_data twice.
2. P valid with data_credits=3 (needs 4) and NP valid eligible -> no grant, no tx for 20 cycles; raise P data_credits to 4 -> P granted, then NP next.
3. NP and CPL both valid and eligible continuously, P idle -> grants alternate NP, CPL, NP, CPL; each NP is a zero-data TLP with a single sop+eop beat.
4. CPL length=0 (1024 DW), data_credits=256 -> consume 256; 128 data beats; with i_tx_ready toggling 1/0, outputs are held while ready=0 and exactly 128 rd_data pulses occur.
5. Assert i_rst during data beat 3 of 8 -> o_tx_valid is 0 in the same cycle; after release, the FSM is in IDLE with no further rd_data and a fresh arbitration.
6. P hdr_credits=0, data ample -> no grant; NP/CPL also blocked.

Source files
------------

// File: rtl/tl_tx_vc_arbiter.sv
// Transmit VC arbiter: picks a TLP from the P/NP/CPL buffer heads under ordering
// and credit rules, serialises it as one header beat plus data beats.
module tl_tx_vc_arbiter #(
  parameter int DW                = 32,
  parameter int HDR_CREDIT_WIDTH  = 8,
  parameter int DATA_CREDIT_WIDTH = 12
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_p_valid,
  input  logic                         i_np_valid,
  input  logic                         i_cpl_valid,
  input  logic                         i_p_has_data,
  input  logic                         i_np_has_data,
  input  logic                         i_cpl_has_data,
  input  logic [9:0]                   i_p_length,
  input  logic [9:0]                   i_np_length,
  input  logic [9:0]                   i_cpl_length,
  input  logic [4*DW-1:0]              i_p_hdr,
  input  logic [4*DW-1:0]              i_np_hdr,
  input  logic [4*DW-1:0]              i_cpl_hdr,
  input  logic [8*DW-1:0]              i_p_data,
  input  logic [8*DW-1:0]              i_np_data,
  input  logic [8*DW-1:0]              i_cpl_data,
  output logic                         o_p_rd_hdr,
  output logic                         o_np_rd_hdr,
  output logic                         o_cpl_rd_hdr,
  output logic                         o_p_rd_data,
  output logic                         o_np_rd_data,
  output logic                         o_cpl_rd_data,
  input  logic [HDR_CREDIT_WIDTH-1:0]  i_p_hdr_credits,
  input  logic [HDR_CREDIT_WIDTH-1:0]  i_np_hdr_credits,
  input  logic [HDR_CREDIT_WIDTH-1:0]  i_cpl_hdr_credits,
  input  logic [DATA_CREDIT_WIDTH-1:0] i_p_data_credits,
  input  logic [DATA_CREDIT_WIDTH-1:0] i_np_data_credits,
  input  logic [DATA_CREDIT_WIDTH-1:0] i_cpl_data_credits,
  output logic [2:0]                   o_fc_consume,
  output logic [DATA_CREDIT_WIDTH-1:0] o_fc_data_consumed,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic                         o_tx_sop,
  output logic                         o_tx_eop,
  output logic [1:0]                   o_tx_type,
  output logic [8*DW-1:0]              o_tx_beat
);

  localparam int CMP_W = (DATA_CREDIT_WIDTH > 9) ? DATA_CREDIT_WIDTH : 9;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_DATA = 2'd2} state_t;

  // Length field 0 encodes 1024 DW; one data credit covers 4 DW.
  function automatic logic [8:0] credits_needed(input logic has_data, input logic [9:0] len);
    logic [10:0] l;
    l = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    credits_needed = has_data ? 9'((l + 11'd3) >> 2) : 9'd0;
  endfunction

  function automatic logic [7:0] beats_needed(input logic [9:0] len);
    logic [10:0] l;
    l = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    beats_needed = 8'((l + 11'd7) >> 3);
  endfunction

  function automatic logic is_eligible(input logic valid,
                                       input logic [HDR_CREDIT_WIDTH-1:0] hdr_cr,
                                       input logic [DATA_CREDIT_WIDTH-1:0] data_cr,
                                       input logic [8:0] need);
    is_eligible = valid && (hdr_cr != {HDR_CREDIT_WIDTH{1'b0}}) &&
                  (CMP_W'(data_cr) >= CMP_W'(need));
  endfunction

  state_t                 state_r;
  logic [1:0]             cls_r;
  logic                   has_data_r;
  logic [4*DW-1:0]        hdr_r;
  logic [7:0]             cnt_r;
  logic                   rr_np_r;

  logic [8:0]             p_need_s, np_need_s, cpl_need_s;
  logic                   p_elig_s, np_elig_s, cpl_elig_s;
  logic                   grant_s;
  logic [1:0]             gcls_s;
  logic                   sel_has_data_s;
  logic [9:0]             sel_len_s;
  logic [4*DW-1:0]        sel_hdr_s;
  logic [8:0]             sel_need_s;
  logic [2:0]             sel_onehot_s;
  logic [8*DW-1:0]        cur_data_s;
  logic                   hdr_pop_s, data_pop_s;

  assign p_need_s   = credits_needed(i_p_has_data, i_p_length);
  assign np_need_s  = credits_needed(i_np_has_data, i_np_length);
  assign cpl_need_s = credits_needed(i_cpl_has_data, i_cpl_length);
  assign p_elig_s   = is_eligible(i_p_valid, i_p_hdr_credits, i_p_data_credits, p_need_s);
  assign np_elig_s  = is_eligible(i_np_valid, i_np_hdr_credits, i_np_data_credits, np_need_s);
  assign cpl_elig_s = is_eligible(i_cpl_valid, i_cpl_hdr_credits, i_cpl_data_credits, cpl_need_s);

  // Arbitration: a valid P head blocks NP/CPL even when it lacks credits.
  always_comb begin
    grant_s = 1'b0;
    gcls_s  = 2'd0;
    if (i_p_valid) begin
      grant_s = p_elig_s;
      gcls_s  = 2'd0;
    end else if (np_elig_s && cpl_elig_s) begin
      grant_s = 1'b1;
      gcls_s  = rr_np_r ? 2'd1 : 2'd2;
    end else if (np_elig_s) begin
      grant_s = 1'b1;
      gcls_s  = 2'd1;
    end else if (cpl_elig_s) begin
      grant_s = 1'b1;
      gcls_s  = 2'd2;
    end else begin
      grant_s = 1'b0;
      gcls_s  = 2'd0;
    end
  end

  // Fields of the class being granted this cycle.
  always_comb begin
    sel_has_data_s = 1'b0;
    sel_len_s      = 10'd0;
    sel_hdr_s      = {(4*DW){1'b0}};
    sel_need_s     = 9'd0;
    sel_onehot_s   = 3'b000;
    case (gcls_s)
      2'd0: begin
        sel_has_data_s = i_p_has_data;
        sel_len_s      = i_p_length;
        sel_hdr_s      = i_p_hdr;
        sel_need_s     = p_need_s;
        sel_onehot_s   = 3'b100;
      end
      2'd1: begin
        sel_has_data_s = i_np_has_data;
        sel_len_s      = i_np_length;
        sel_hdr_s      = i_np_hdr;
        sel_need_s     = np_need_s;
        sel_onehot_s   = 3'b010;
      end
      2'd2: begin
        sel_has_data_s = i_cpl_has_data;
        sel_len_s      = i_cpl_length;
        sel_hdr_s      = i_cpl_hdr;
        sel_need_s     = cpl_need_s;
        sel_onehot_s   = 3'b001;
      end
      default: begin
        sel_has_data_s = 1'b0;
        sel_len_s      = 10'd0;
        sel_hdr_s      = {(4*DW){1'b0}};
        sel_need_s     = 9'd0;
        sel_onehot_s   = 3'b000;
      end
    endcase
  end

  // Data beats stream straight from the latched class's buffer head.
  always_comb begin
    cur_data_s = {(8*DW){1'b0}};
    case (cls_r)
      2'd0:    cur_data_s = i_p_data;
      2'd1:    cur_data_s = i_np_data;
      2'd2:    cur_data_s = i_cpl_data;
      default: cur_data_s = {(8*DW){1'b0}};
    endcase
  end

  // Beat payload: header beat is zero-padded, data beats pass through.
  always_comb begin
    o_tx_beat = {(8*DW){1'b0}};
    if (state_r == ST_HDR) begin
      o_tx_beat = {{(4*DW){1'b0}}, hdr_r};
    end else if (state_r == ST_DATA) begin
      o_tx_beat = cur_data_s;
    end else begin
      o_tx_beat = {(8*DW){1'b0}};
    end
  end

  // Pops fire on the accepting edge so the next head beat is ready in time.
  assign hdr_pop_s     = (state_r == ST_HDR)  && o_tx_valid && i_tx_ready;
  assign data_pop_s    = (state_r == ST_DATA) && o_tx_valid && i_tx_ready;
  assign o_p_rd_hdr    = hdr_pop_s  && (cls_r == 2'd0);
  assign o_np_rd_hdr   = hdr_pop_s  && (cls_r == 2'd1);
  assign o_cpl_rd_hdr  = hdr_pop_s  && (cls_r == 2'd2);
  assign o_p_rd_data   = data_pop_s && (cls_r == 2'd0);
  assign o_np_rd_data  = data_pop_s && (cls_r == 2'd1);
  assign o_cpl_rd_data = data_pop_s && (cls_r == 2'd2);

  // Main FSM with registered beat-control and credit-consume outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r            <= ST_IDLE;
      cls_r              <= 2'd0;
      has_data_r         <= 1'b0;
      hdr_r              <= {(4*DW){1'b0}};
      cnt_r              <= 8'd0;
      rr_np_r            <= 1'b1;
      o_fc_consume       <= 3'b000;
      o_fc_data_consumed <= {DATA_CREDIT_WIDTH{1'b0}};
      o_tx_valid         <= 1'b0;
      o_tx_sop           <= 1'b0;
      o_tx_eop           <= 1'b0;
      o_tx_type          <= 2'd0;
    end else begin
      o_fc_consume       <= 3'b000;
      o_fc_data_consumed <= {DATA_CREDIT_WIDTH{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            cls_r              <= gcls_s;
            has_data_r         <= sel_has_data_s;
            hdr_r              <= sel_hdr_s;
            cnt_r              <= beats_needed(sel_len_s);
            o_fc_consume       <= sel_onehot_s;
            o_fc_data_consumed <= DATA_CREDIT_WIDTH'(sel_need_s);
            o_tx_valid         <= 1'b1;
            o_tx_sop           <= 1'b1;
            o_tx_eop           <= !sel_has_data_s;
            o_tx_type          <= gcls_s;
            state_r            <= ST_HDR;
            if (gcls_s != 2'd0) begin
              rr_np_r <= (gcls_s == 2'd2);
            end
          end
        end
        ST_HDR: begin
          if (i_tx_ready) begin
            o_tx_sop <= 1'b0;
            if (has_data_r) begin
              o_tx_eop <= (cnt_r == 8'd1);
              state_r  <= ST_DATA;
            end else begin
              o_tx_valid <= 1'b0;
              o_tx_eop   <= 1'b0;
              o_tx_type  <= 2'd0;
              state_r    <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (i_tx_ready) begin
            cnt_r <= cnt_r - 8'd1;
            if (cnt_r == 8'd1) begin
              o_tx_valid <= 1'b0;
              o_tx_eop   <= 1'b0;
              o_tx_type  <= 2'd0;
              state_r    <= ST_IDLE;
            end else begin
              o_tx_eop <= (cnt_r == 8'd2);
            end
          end
        end
        default: begin
          o_tx_valid <= 1'b0;
          o_tx_sop   <= 1'b0;
          o_tx_eop   <= 1'b0;
          o_tx_type  <= 2'd0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_tx_vc_arbiter.sv
// Directed bench for tl_tx_vc_arbiter: ordering, credit gating, beat framing,
// link back-pressure and mid-TLP reset.
module tb_tl_tx_vc_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         p_valid, np_valid, cpl_valid;
  logic         p_has_data, np_has_data, cpl_has_data;
  logic [9:0]   p_length, np_length, cpl_length;
  logic [127:0] p_hdr, np_hdr, cpl_hdr;
  logic [255:0] p_data, np_data, cpl_data;
  logic         p_rd_hdr, np_rd_hdr, cpl_rd_hdr;
  logic         p_rd_data, np_rd_data, cpl_rd_data;
  logic [7:0]   p_hdr_cr, np_hdr_cr, cpl_hdr_cr;
  logic [11:0]  p_data_cr, np_data_cr, cpl_data_cr;
  logic [2:0]   fc_consume;
  logic [11:0]  fc_data_consumed;
  logic         tx_valid, tx_ready, tx_sop, tx_eop;
  logic [1:0]   tx_type;
  logic [255:0] tx_beat;

  int n_cmp = 0;
  int n_err = 0;

  int p_hdr_cnt = 0, p_data_cnt = 0, cpl_data_cnt = 0, cpl_hdr_cnt = 0;
  int fc_cnt = 0, tx_cnt = 0;

  tl_tx_vc_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_p_valid(p_valid), .i_np_valid(np_valid), .i_cpl_valid(cpl_valid),
    .i_p_has_data(p_has_data), .i_np_has_data(np_has_data), .i_cpl_has_data(cpl_has_data),
    .i_p_length(p_length), .i_np_length(np_length), .i_cpl_length(cpl_length),
    .i_p_hdr(p_hdr), .i_np_hdr(np_hdr), .i_cpl_hdr(cpl_hdr),
    .i_p_data(p_data), .i_np_data(np_data), .i_cpl_data(cpl_data),
    .o_p_rd_hdr(p_rd_hdr), .o_np_rd_hdr(np_rd_hdr), .o_cpl_rd_hdr(cpl_rd_hdr),
    .o_p_rd_data(p_rd_data), .o_np_rd_data(np_rd_data), .o_cpl_rd_data(cpl_rd_data),
    .i_p_hdr_credits(p_hdr_cr), .i_np_hdr_credits(np_hdr_cr), .i_cpl_hdr_credits(cpl_hdr_cr),
    .i_p_data_credits(p_data_cr), .i_np_data_credits(np_data_cr), .i_cpl_data_credits(cpl_data_cr),
    .o_fc_consume(fc_consume), .o_fc_data_consumed(fc_data_consumed),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_sop(tx_sop), .o_tx_eop(tx_eop),
    .o_tx_type(tx_type), .o_tx_beat(tx_beat)
  );

  always #5 clk = ~clk;

  // Event counters sampled at the active edge.
  always @(posedge clk) begin
    if (p_rd_hdr)       p_hdr_cnt    <= p_hdr_cnt + 1;
    if (p_rd_data)      p_data_cnt   <= p_data_cnt + 1;
    if (cpl_rd_hdr)     cpl_hdr_cnt  <= cpl_hdr_cnt + 1;
    if (cpl_rd_data)    cpl_data_cnt <= cpl_data_cnt + 1;
    if (fc_consume != 3'b000) fc_cnt <= fc_cnt + 1;
    if (tx_valid)       tx_cnt       <= tx_cnt + 1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p_valid = 1'b0; np_valid = 1'b0; cpl_valid = 1'b0;
    p_has_data = 1'b0; np_has_data = 1'b0; cpl_has_data = 1'b0;
    p_length = 10'd0; np_length = 10'd0; cpl_length = 10'd0;
    p_hdr = 128'h0; np_hdr = 128'h0; cpl_hdr = 128'h0;
    p_data = 256'h0; np_data = 256'h0; cpl_data = 256'h0;
    p_hdr_cr = 8'd0; np_hdr_cr = 8'd0; cpl_hdr_cr = 8'd0;
    p_data_cr = 12'd0; np_data_cr = 12'd0; cpl_data_cr = 12'd0;
    tx_ready = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  int p_hdr0, p_data0, cpl_hdr0, cpl_data0, fc0, tx0;
  int hold_err, beat_err, eop_cnt;
  logic held, held_eop, pop;
  logic [255:0] held_beat;

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick(2);
    // Reset state
    check("rst_valid", tx_valid, 1'b0);
    check("rst_sop_eop_type", {tx_sop, tx_eop, tx_type}, 4'b0000);
    check("rst_beat", tx_beat, 256'h0);
    check("rst_fc", {fc_consume, fc_data_consumed}, 15'h0);
    check("rst_pops", {p_rd_hdr, np_rd_hdr, cpl_rd_hdr, p_rd_data, np_rd_data, cpl_rd_data}, 6'b0);
    rst = 1'b0;
    tick(1);

    // 1: P len=16 -> 4 credits, 2 data beats
    p_hdr0 = p_hdr_cnt; p_data0 = p_data_cnt;
    p_valid = 1'b1; p_has_data = 1'b1; p_length = 10'd16;
    p_hdr_cr = 8'd1; p_data_cr = 12'd4;
    p_hdr = 128'hA5A5_0001_0002_0003_0004_0005_0006_0007;
    p_data = {8{32'h1111_0001}};
    tick(1);
    check("t1_hdr_ctl", {tx_valid, tx_sop, tx_eop, tx_type}, 5'b11000);
    check("t1_consume", {fc_consume, fc_data_consumed}, {3'b100, 12'd4});
    check("t1_hdr_beat", tx_beat, {128'h0, 128'hA5A5_0001_0002_0003_0004_0005_0006_0007});
    p_valid = 1'b0;
    tick(1);
    check("t1_d1_ctl", {tx_valid, tx_sop, tx_eop}, 3'b100);
    check("t1_d1_beat", tx_beat, {8{32'h1111_0001}});
    check("t1_consume_once", fc_consume, 3'b000);
    p_data = {8{32'h2222_0002}};
    tick(1);
    check("t1_d2_ctl", {tx_valid, tx_sop, tx_eop}, 3'b101);
    check("t1_d2_beat", tx_beat, {8{32'h2222_0002}});
    tick(1);
    check("t1_idle", tx_valid, 1'b0);
    check("t1_pop_counts", {p_hdr_cnt - p_hdr0, p_data_cnt - p_data0}, {32'd1, 32'd2});

    // 2: starved P blocks eligible NP; exact credit grants
    do_reset();
    p_valid = 1'b1; p_has_data = 1'b1; p_length = 10'd16;
    p_hdr_cr = 8'd5; p_data_cr = 12'd3;
    np_valid = 1'b1; np_has_data = 1'b0; np_hdr_cr = 8'd1;
    fc0 = fc_cnt; tx0 = tx_cnt;
    tick(20);
    check("t2_no_tx", tx_cnt - tx0, 32'd0);
    check("t2_no_consume", fc_cnt - fc0, 32'd0);
    p_data_cr = 12'd4;
    tick(1);
    check("t2_p_grant", {tx_valid, tx_sop, tx_type, fc_consume}, {1'b1, 1'b1, 2'b00, 3'b100});
    p_valid = 1'b0;
    tick(4);
    check("t2_np_next", {tx_valid, tx_sop, tx_eop, tx_type, fc_consume}, {3'b111, 2'b01, 3'b010});
    check("t2_np_zero_data", fc_data_consumed, 12'd0);
    np_valid = 1'b0;

    // 3: NP/CPL round-robin, zero-data TLPs
    do_reset();
    np_valid = 1'b1; np_hdr_cr = 8'd1;
    cpl_valid = 1'b1; cpl_hdr_cr = 8'd1;
    tick(1);
    check("t3_g1_np", {tx_valid, tx_sop, tx_eop, tx_type, fc_consume}, {3'b111, 2'b01, 3'b010});
    tick(1);
    check("t3_gap", tx_valid, 1'b0);
    tick(1);
    check("t3_g2_cpl", {tx_valid, tx_sop, tx_eop, tx_type, fc_consume}, {3'b111, 2'b10, 3'b001});
    tick(2);
    check("t3_g3_np", {tx_type, fc_consume}, {2'b01, 3'b010});
    tick(2);
    check("t3_g4_cpl", {tx_type, fc_consume}, {2'b10, 3'b001});
    np_valid = 1'b0; cpl_valid = 1'b0;

    // 4: CPL 1024 DW with exactly 256 credits, ready toggling
    do_reset();
    cpl_hdr0 = cpl_hdr_cnt; cpl_data0 = cpl_data_cnt;
    cpl_valid = 1'b1; cpl_has_data = 1'b1; cpl_length = 10'd0;
    cpl_hdr_cr = 8'd1; cpl_data_cr = 12'd256;
    cpl_data = 256'd1000;
    tick(1);
    check("t4_consume", {fc_consume, fc_data_consumed}, {3'b001, 12'd256});
    cpl_valid = 1'b0;
    hold_err = 0; beat_err = 0; eop_cnt = 0; held = 1'b0; held_eop = 1'b0; held_beat = 256'h0;
    for (int i = 0; i < 300; i++) begin
      tx_ready = (i % 2 == 0);
      #1;
      if (held && (tx_valid !== 1'b1 || tx_eop !== held_eop || tx_beat !== held_beat)) hold_err++;
      if (tx_valid && !tx_sop && tx_beat !== cpl_data) beat_err++;
      if (tx_valid && tx_eop && tx_ready) eop_cnt++;
      held = tx_valid && !tx_ready;
      held_eop = tx_eop;
      held_beat = tx_beat;
      pop = cpl_rd_data;
      @(posedge clk);
      #1;
      if (pop) cpl_data = cpl_data + 256'd1;
    end
    tx_ready = 1'b1;
    check("t4_rd_data_cnt", cpl_data_cnt - cpl_data0, 32'd128);
    check("t4_rd_hdr_cnt", cpl_hdr_cnt - cpl_hdr0, 32'd1);
    check("t4_hold", hold_err, 32'd0);
    check("t4_beats", beat_err, 32'd0);
    check("t4_eop_cnt", eop_cnt, 32'd1);
    check("t4_done", tx_valid, 1'b0);

    // 5: reset during data beat 3 of 8
    do_reset();
    p_valid = 1'b1; p_has_data = 1'b1; p_length = 10'd64;
    p_hdr_cr = 8'd1; p_data_cr = 12'd16;
    p_data = {8{32'hCAFE_0005}};
    tick(1);
    check("t5_consume", {fc_consume, fc_data_consumed}, {3'b100, 12'd16});
    p_valid = 1'b0;
    tick(3);
    p_data0 = p_data_cnt;
    check("t5_beat3", {tx_valid, tx_eop, tx_beat}, {2'b10, {8{32'hCAFE_0005}}});
    #2 rst = 1'b1;
    #1;
    check("t5_async_clear", {tx_valid, tx_sop, tx_eop, p_rd_data, fc_consume}, 7'b0);
    tick(1);
    rst = 1'b0;
    tick(3);
    check("t5_no_more_pops", p_data_cnt - p_data0, 32'd0);
    check("t5_idle", tx_valid, 1'b0);
    np_valid = 1'b1; np_hdr_cr = 8'd1;
    tick(1);
    check("t5_fresh_arb", {tx_valid, tx_sop, tx_type}, {2'b11, 2'b01});
    np_valid = 1'b0;

    // 6: P without header credit blocks everything
    do_reset();
    p_valid = 1'b1; p_has_data = 1'b1; p_length = 10'd4;
    p_hdr_cr = 8'd0; p_data_cr = 12'd100;
    np_valid = 1'b1; np_hdr_cr = 8'd1;
    cpl_valid = 1'b1; cpl_hdr_cr = 8'd1;
    tx0 = tx_cnt; fc0 = fc_cnt;
    tick(10);
    check("t6_blocked_tx", tx_cnt - tx0, 32'd0);
    check("t6_blocked_fc", fc_cnt - fc0, 32'd0);
    p_hdr_cr = 8'd1;
    tick(1);
    check("t6_p_grant", {tx_type, fc_consume, fc_data_consumed}, {2'b00, 3'b100, 12'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
